// File: rtl/command_queue.sv
// Command FIFO feeding the atomic ALU controller: one command per syscall strobe,
// with a 2-cycle issue spacing for normal opcodes and 3 cycles after a CAS.
module command_queue #(
    parameter int         DEPTH  = 8,
    parameter int         CMD_W  = 12,
    parameter logic [2:0] CAS_OP = 3'b111
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CMD_W-1:0]       cmd_in,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   hold,
    output logic [CMD_W-1:0]       command,
    output logic                   syscall,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_GAP      = 2'd2,
        S_CAS_WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CMD_W-1:0]   command_q, command_d;
    logic               syscall_q, syscall_d;
    logic [CMD_W-1:0]   mem_q [DEPTH];

    logic push, pop, can_issue;

    assign cmd_ready = (count_q != CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign idle      = (state_q == S_IDLE) && empty;
    assign count     = count_q;
    assign command   = command_q;
    assign syscall   = syscall_q;

    assign push      = cmd_valid && cmd_ready;
    assign can_issue = !empty && !hold;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_issue) begin
                    state_d = S_ISSUE;
                    pop     = 1'b1;
                end
            end
            S_ISSUE: state_d = S_GAP;
            S_GAP: begin
                // The opcode of the command just issued decides the extra wait cycle.
                if (command_q[CMD_W-1 -: 3] == CAS_OP) begin
                    state_d = S_CAS_WAIT;
                end else if (can_issue) begin
                    state_d = S_ISSUE;
                    pop     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAS_WAIT: begin
                if (can_issue) begin
                    state_d = S_ISSUE;
                    pop     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        command_d = command_q;
        syscall_d = pop;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (pop) begin
            command_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            command_q <= '0;
            syscall_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            command_q <= command_d;
            syscall_q <= syscall_d;
        end
    end

    // Storage has no reset; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

endmodule

// File: tb/tb_command_queue.sv
// Bench for command_queue: directed scenarios plus random traffic, all checked
// against a queue-and-spacing model of the issue rules.
module tb_command_queue;

    localparam int DEPTH = 8;
    localparam int CMD_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CMD_W-1:0] cmd_in = '0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             hold = 1'b0;
    logic [CMD_W-1:0] command;
    logic             syscall;
    logic [3:0]       count;
    logic             empty, full, idle;

    command_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W), .CAS_OP(3'b111)) dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .hold(hold), .command(command), .syscall(syscall),
        .count(count), .empty(empty), .full(full), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: a plain FIFO plus the number of edges that must pass
    // before another issue is permitted.
    logic [CMD_W-1:0] mq[$];
    logic [CMD_W-1:0] m_cmd = '0;
    logic             m_sys = 1'b0;
    int               m_cool = 0;
    bit               m_fsm_idle = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic v, input logic [CMD_W-1:0] d, input logic h, input logic r);
        bit issue, accept;
        if (r) begin
            mq.delete();
            m_cmd = '0; m_sys = 1'b0; m_cool = 0; m_fsm_idle = 1'b1;
        end else begin
            issue  = (m_cool == 0) && (mq.size() > 0) && !h;
            accept = v && (mq.size() != DEPTH);
            m_sys  = issue;
            if (issue) begin
                m_cmd      = mq.pop_front();
                m_cool     = (m_cmd[11:9] == 3'b111) ? 2 : 1;
                m_fsm_idle = 1'b0;
            end else if (m_cool > 0) begin
                m_cool--;
                m_fsm_idle = 1'b0;
            end else begin
                m_fsm_idle = 1'b1;
            end
            if (accept) mq.push_back(d);
        end
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        chk("syscall",   32'(syscall),   32'(m_sys));
        chk("command",   32'(command),   32'(m_cmd));
        chk("count",     32'(count),     32'(n));
        chk("empty",     32'(empty),     32'(n == 0));
        chk("full",      32'(full),      32'(n == DEPTH));
        chk("cmd_ready", 32'(cmd_ready), 32'(n != DEPTH));
        chk("idle",      32'(idle),      32'(m_fsm_idle && n == 0));
    endtask

    task automatic step(input logic v, input logic [CMD_W-1:0] d, input logic h, input logic r);
        cmd_valid = v; cmd_in = d; hold = h; rst = r;
        @(posedge clk);
        model_edge(v, d, h, r);
        #1;
        compare_all();
    endtask

    function automatic logic [CMD_W-1:0] pat(input int k);
        return CMD_W'(k * 12'h247 + 12'h05);
    endfunction

    logic [CMD_W-1:0] exp_order[$];
    logic [CMD_W-1:0] got_order[$];
    logic             sys_seen[8];

    initial begin
        // Reset held two cycles with cmd_valid asserted.
        step(1'b1, 12'hABC, 1'b0, 1'b1);
        step(1'b1, 12'hABC, 1'b0, 1'b1);
        chk("rst_command", 32'(command), 32'h0);
        chk("rst_syscall", 32'(syscall), 32'h0);
        chk("rst_count",   32'(count),   32'h0);
        chk("rst_empty",   32'(empty),   32'h1);
        chk("rst_full",    32'(full),    32'h0);
        chk("rst_ready",   32'(cmd_ready), 32'h1);
        chk("rst_idle",    32'(idle),    32'h1);

        // Single issue.
        step(1'b1, 12'h0D1, 1'b0, 1'b0);
        chk("single_e0_sys", 32'(syscall), 32'h0);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        chk("single_e1_sys", 32'(syscall), 32'h1);
        chk("single_e1_cmd", 32'(command), 32'h0D1);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        chk("single_e2_sys",  32'(syscall), 32'h0);
        chk("single_e2_idle", 32'(idle), 32'h0);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        chk("single_e3_idle", 32'(idle), 32'h1);

        // Back-to-back with a CAS in the middle.
        for (int e = 0; e < 8; e++) begin
            case (e)
                0: step(1'b1, 12'h2C8, 1'b0, 1'b0);
                1: step(1'b1, 12'hE53, 1'b0, 1'b0);
                2: step(1'b1, 12'h10A, 1'b0, 1'b0);
                default: step(1'b0, 12'h000, 1'b0, 1'b0);
            endcase
            sys_seen[e] = syscall;
            if (e >= 3 && e <= 5) chk("b2b_cas_held", 32'(command), 32'hE53);
            if (e == 6) chk("b2b_e6_cmd", 32'(command), 32'h10A);
        end
        for (int e = 0; e < 8; e++)
            chk($sformatf("b2b_sys_e%0d", e), 32'(sys_seen[e]), 32'(e == 1 || e == 3 || e == 6));
        step(1'b0, 12'h000, 1'b0, 1'b0);

        // Fill under hold, overflow, then drain with pushes for 20 commands total.
        step(1'b0, 12'h000, 1'b0, 1'b1);
        exp_order.delete(); got_order.delete();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, pat(i), 1'b1, 1'b0);
            if (i < 8) exp_order.push_back(pat(i));
            if (i == 7) begin
                chk("fill_ready_after8", 32'(cmd_ready), 32'h0);
                chk("fill_full_after8",  32'(full),      32'h1);
            end
        end
        chk("fill_count_after9", 32'(count), 32'h8);
        begin
            int k = 8;
            int cyc = 0;
            while (got_order.size() < 20 && cyc < 200) begin
                logic v;
                v = (k < 20) && cmd_ready;
                step(v, pat(k), 1'b0, 1'b0);
                if (v) begin exp_order.push_back(pat(k)); k++; end
                if (syscall) got_order.push_back(command);
                cyc++;
            end
            chk("drain_issued", 32'(got_order.size()), 32'd20);
            for (int i = 0; i < got_order.size() && i < exp_order.size(); i++)
                chk($sformatf("drain_order_%0d", i), 32'(got_order[i]), 32'(exp_order[i]));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 12'h000, 1'b0, 1'b0);

        // Hold asserted across ISSUE and GAP.
        step(1'b1, 12'h0A1, 1'b0, 1'b0);
        step(1'b1, 12'h0B2, 1'b0, 1'b0);
        chk("hold_e1_sys", 32'(syscall), 32'h1);
        for (int e = 2; e <= 5; e++) begin
            step(1'b0, 12'h000, 1'b1, 1'b0);
            chk("hold_no_sys", 32'(syscall), 32'h0);
        end
        chk("hold_count", 32'(count), 32'h1);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        chk("hold_resume_sys", 32'(syscall), 32'h1);
        chk("hold_resume_cmd", 32'(command), 32'h0B2);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b0, 1'b0);

        // Reset while in CAS_WAIT with three commands still queued.
        step(1'b1, 12'hE11, 1'b1, 1'b0);
        step(1'b1, 12'h101, 1'b1, 1'b0);
        step(1'b1, 12'h102, 1'b1, 1'b0);
        step(1'b1, 12'h103, 1'b1, 1'b0);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        chk("rcas_issue_sys", 32'(syscall), 32'h1);
        chk("rcas_issue_cmd", 32'(command), 32'hE11);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        chk("rcas_wait_count", 32'(count), 32'h3);
        step(1'b0, 12'h000, 1'b0, 1'b1);
        chk("rcas_rst_sys",   32'(syscall), 32'h0);
        chk("rcas_rst_count", 32'(count),   32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 12'h000, 1'b0, 1'b0);
            chk("rcas_after_sys", 32'(syscall), 32'h0);
        end
        chk("rcas_after_idle", 32'(idle), 32'h1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic v, h, r;
            v = ($urandom_range(0, 3) != 0);
            h = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 99) == 0);
            step(v, CMD_W'($urandom), h, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/command_queue.md
# command_queue

Buffers 12-bit ALU commands from the host side and issues them one at a time to the atomic ALU controller. For each command it drives `command` and a one-cycle `syscall` pulse, and it enforces the minimum spacing the controller needs: 2 cycles between normal operations, 3 cycles after a CAS (opcode 3'b111). It sits directly upstream of the controller: its `command` and `syscall` outputs connect straight to the controller's inputs of the same names.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; must be a power of 2, ≥ 2.
- `CMD_W`, 12: command width. Bits [11:9] are the opcode; [8:6], [5:3] and [2:0] are addr1, addr2 and addr3.
- `CAS_OP`, 3'b111: opcode that triggers the extended CAS gap.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_in`  in  CMD_W  command from host.
- `cmd_valid`  in  1  `cmd_in` is valid this cycle.
- `cmd_ready`  out  1  queue can accept; equals (count != DEPTH).
- `hold`  in  1  when high, no new issue starts; an issue already in progress completes.
- `command`  out  CMD_W  registered command to the controller.
- `syscall`  out  1  registered one-cycle issue strobe.
- `count`  out  $clog2(DEPTH)+1  entries currently queued.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `idle`  out  1  FSM is in IDLE and count == 0.

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. A separate count register tracks occupancy.
- Push: occurs on an edge where cmd_valid && cmd_ready. The entry is written at wr_ptr and wr_ptr increments.
- Pop: occurs only on an edge that enters ISSUE. The head entry is loaded into `command` and rd_ptr increments.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, cmd_ready = 0 even if a pop happens in the same cycle. A push while full is dropped, with no state change.
- FSM states and transitions:
  - IDLE, syscall = 0: if !empty && !hold, go to ISSUE (with pop). Otherwise stay in IDLE.
  - ISSUE, syscall = 1 for exactly one cycle: always go to GAP.
  - GAP, syscall = 0:
    - If command[11:9] == CAS_OP, go to CAS_WAIT.
    - Else if !empty && !hold, go to ISSUE (with pop).
    - Else go to IDLE.
  - CAS_WAIT, syscall = 0: if !empty && !hold, go to ISSUE (with pop). Otherwise go to IDLE.
- `command` changes only on an edge entering ISSUE. It holds its value through GAP, CAS_WAIT and IDLE.
- `hold` is sampled only in IDLE, GAP and CAS_WAIT. Asserting it during ISSUE has no effect on that issue.
- The opcode is not otherwise interpreted; all eight opcodes are passed through unchanged.

## Timing
- Reset values: command = 0, syscall = 0, count = 0, empty = 1, full = 0, cmd_ready = 1, idle = 1. Pointers are 0 and the FSM is in IDLE. Queue contents are don't-care.
- Reset takes priority over every other event. Reset asserted mid-issue, including during CAS_WAIT, discards all queued commands and drops syscall on the next edge.
- Latency with the queue empty and the FSM in IDLE:
  - Command accepted at edge t.
  - Pop and FSM move to ISSUE at edge t+1.
  - `command` and syscall = 1 are valid during cycle t+1 to t+2.
- Issue spacing, measured between syscall rising edges:
  - 2 cycles after a non-CAS command (syscall alternates 1, 0).
  - 3 cycles after a CAS command (syscall pattern 1, 0, 0).
- Maximum throughput is one non-CAS command every 2 cycles.
- cmd_ready, empty, full and idle are combinational from registered state; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst for 2 cycles with cmd_valid = 1. Required: all outputs at reset values and count stays 0.
- Single issue: push 12'h0D1 (opcode 000) into an empty queue at edge 0. Required: syscall = 1 only in cycle 1 to 2, command = 12'h0D1, idle returns to 1 at edge 3.
- Back-to-back with CAS:
  - Stimulus: push 12'h2C8, then 12'hE53 (CAS), then 12'h10A on consecutive cycles.
  - Required: syscall high in the cycles after edges 1, 3 and 6.
  - Required: command = 12'hE53 held unchanged from edge 3 to edge 6.
- Full/wrap with DEPTH = 8:
  - Stimulus: assert hold, push 9 commands.
  - Required: cmd_ready = 0 after the 8th push, the 9th is dropped, full = 1, count = 8.
  - Then: release hold, push during the drain, and run 20 commands total. Required: pointers wrap and output order exactly matches input order.
- Hold mid-stream: assert hold during the GAP cycle. Required: the FSM goes to IDLE, no syscall while hold = 1, and issue resumes one edge after hold falls.
- Reset mid-CAS: with 3 entries queued, assert rst during CAS_WAIT. Required: syscall stays 0 afterwards, count = 0, and no further issue occurs after reset is released.
